// File: rtl/regfile_arb_pkg.sv
// Shared types and sizes for the dual-source register file front-end.
// Optional read bypass is selected by the WR_BYPASS_EN macro in the top.
package regfile_arb_pkg;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_state_t;

  typedef logic [AW-1:0] addr_t;
  typedef logic [DW-1:0] data_t;

endpackage

// File: rtl/dual_src_regfile_arb_rr2_arbiter.sv
// Two-requester priority FSM: the winner of a contention cycle
// hands priority to the loser, so neither source can starve.
module rr2_arbiter
  import regfile_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  output logic grant_a,
  output logic grant_b
);

  prio_state_t state_q;
  prio_state_t state_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PRIO_A;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!rst) begin
      unique case (state_q)
        PRIO_A: begin
          grant_a = req_a;
          grant_b = req_b & ~req_a;
          if (req_a && req_b) begin
            state_d = PRIO_B;
          end
        end
        PRIO_B: begin
          grant_b = req_b;
          grant_a = req_a & ~req_b;
          if (req_a && req_b) begin
            state_d = PRIO_A;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/dual_src_regfile_arb.sv
// Single-driver write front-end for a 16x8 register array.
// Define WR_BYPASS_EN for write-first reads; default is read-first.
module dual_src_regfile_arb
  import regfile_arb_pkg::*;
#(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_data,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          busy_both,
  output logic [CW-1:0] coll_cnt
);

  logic  grant_a;
  logic  grant_b;
  logic  wr_en;
  addr_t wr_addr;
  data_t wr_data;

  data_t         mem_q [DEPTH];
  data_t         rd_q;
  data_t         rd_d;
  logic          busy_q;
  logic [CW-1:0] coll_q;
  logic [CW-1:0] coll_d;

  rr2_arbiter u_arb (
    .clk     (clk),
    .rst     (rst),
    .req_a   (a_valid),
    .req_b   (b_valid),
    .grant_a (grant_a),
    .grant_b (grant_b)
  );

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  always_comb begin
    wr_en   = grant_a | grant_b;
    wr_addr = grant_a ? a_addr : b_addr;
    wr_data = grant_a ? a_data : b_data;
  end

  always_comb begin
    rd_d = mem_q[rd_addr];
`ifdef WR_BYPASS_EN
    if (wr_en && (wr_addr == rd_addr)) begin
      rd_d = wr_data;
    end
`endif
  end

  // Same-address contention only; saturates instead of wrapping.
  always_comb begin
    coll_d = coll_q;
    if (a_valid && b_valid && (a_addr == b_addr)
        && (coll_q != {CW{1'b1}})) begin
      coll_d = coll_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q   <= '0;
      busy_q <= 1'b0;
      coll_q <= '0;
    end else begin
      rd_q   <= rd_d;
      busy_q <= a_valid & b_valid;
      coll_q <= coll_d;
    end
  end

  assign rd_data   = rd_q;
  assign busy_both = busy_q;
  assign coll_cnt  = coll_q;

endmodule

// File: tb/tb_dual_src_regfile_arb.sv
// Scoreboard bench for dual_src_regfile_arb.
// Reference model tracks array, priority, busy and collision count.
module tb_dual_src_regfile_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_valid;
  logic       a_ready;
  logic [3:0] a_addr;
  logic [7:0] a_data;
  logic       b_valid;
  logic       b_ready;
  logic [3:0] b_addr;
  logic [7:0] b_data;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       busy_both;
  logic [7:0] coll_cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] m_mem [16];
  logic       m_prio_b;
  int         m_coll;
  logic       m_busy;
  logic [7:0] rdq [$];

  always #5 clk = ~clk;

  dual_src_regfile_arb dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_addr    (a_addr),
    .a_data    (a_data),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_addr    (b_addr),
    .b_data    (b_data),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .busy_both (busy_both),
    .coll_cnt  (coll_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               tag, act, exp, $time);
    end
  endtask

  // Called after inputs are driven; returns at the next falling edge.
  task automatic step();
    logic       ga;
    logic       gb;
    logic [3:0] wa;
    logic [7:0] wd;
    logic [7:0] exp_rd;
    #1;
    ga = !rst && a_valid && (m_prio_b ? !b_valid : 1'b1);
    gb = !rst && b_valid && (m_prio_b ? 1'b1 : !a_valid);
    chk("a_ready", 32'(a_ready), 32'(ga));
    chk("b_ready", 32'(b_ready), 32'(gb));
    wa = ga ? a_addr : b_addr;
    wd = ga ? a_data : b_data;
    if (rst) begin
      exp_rd = 8'h00;
    end else begin
      exp_rd = m_mem[rd_addr];
`ifdef WR_BYPASS_EN
      if ((ga || gb) && (wa == rd_addr)) exp_rd = wd;
`endif
    end
    rdq.push_back(exp_rd);
    if (rst) begin
      for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
      m_prio_b = 1'b0;
      m_coll   = 0;
      m_busy   = 1'b0;
    end else begin
      if (ga || gb) m_mem[wa] = wd;
      if (a_valid && b_valid) begin
        m_prio_b = !m_prio_b;
        if (a_addr == b_addr && m_coll < 255) m_coll++;
      end
      m_busy = a_valid && b_valid;
    end
    @(posedge clk);
    #1;
    chk("rd_data", 32'(rd_data), 32'(rdq.pop_front()));
    chk("busy_both", 32'(busy_both), 32'(m_busy));
    chk("coll_cnt", 32'(coll_cnt), 32'(m_coll));
    @(negedge clk);
  endtask

  task automatic idle();
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) step();
    rst = 1'b0;
  endtask

  task automatic read_at(input logic [3:0] adr);
    idle();
    rd_addr = adr;
    step();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    a_addr  = '0;
    a_data  = '0;
    b_addr  = '0;
    b_data  = '0;
    rd_addr = '0;
    for (int i = 0; i < 16; i++) m_mem[i] = 8'hEE;
    m_prio_b = 1'b0;
    m_coll   = 0;
    m_busy   = 1'b0;
    @(negedge clk);

    // Reset then sweep every address.
    do_reset(3);
    for (int i = 0; i < 16; i++) read_at(4'(i));

    // Source A alone.
    a_valid = 1'b1; a_addr = 4'd3;  a_data = 8'hA5; step();
    a_valid = 1'b1; a_addr = 4'd15; a_data = 8'h3C; step();
    read_at(4'd3);
    read_at(4'd15);
    chk("mem3_direct", 32'(m_mem[3]), 32'h0000_00A5);

    // Contention on different addresses, B held until accepted.
    a_valid = 1'b1; a_addr = 4'd2; a_data = 8'h11;
    b_valid = 1'b1; b_addr = 4'd5; b_data = 8'h22;
    step();
    a_valid = 1'b0;
    step();
    read_at(4'd2);
    read_at(4'd5);

    // Long same-address contention: alternating grants, saturation.
    a_valid = 1'b1; a_addr = 4'd7; a_data = 8'h77;
    b_valid = 1'b1; b_addr = 4'd7; b_data = 8'h88;
    rd_addr = 4'd0;
    for (int i = 0; i < 300; i++) step();
    read_at(4'd7);

    // Write and read the same index in one cycle.
    a_valid = 1'b1; a_addr = 4'd4; a_data = 8'h5A;
    rd_addr = 4'd4;
    step();
    read_at(4'd4);

    // Reset while both sources request.
    a_valid = 1'b1; a_addr = 4'd9; a_data = 8'hFF;
    b_valid = 1'b1; b_addr = 4'd9; b_data = 8'hC3;
    do_reset(2);
    read_at(4'd9);
    a_valid = 1'b1; a_addr = 4'd10; a_data = 8'h01;
    b_valid = 1'b1; b_addr = 4'd11; b_data = 8'h02;
    step();
    idle();
    read_at(4'd10);
    read_at(4'd11);

    // Random traffic.
    for (int i = 0; i < 200; i++) begin
      a_valid = 1'($urandom);
      b_valid = 1'($urandom);
      a_addr  = 4'($urandom);
      b_addr  = 4'($urandom_range(0, 3));
      a_data  = 8'($urandom);
      b_data  = 8'($urandom);
      rd_addr = 4'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
